// File: rtl/apb_pkg.sv
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared APB completer types and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } apb_slv_state_t;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_req_t;

endpackage

`default_nettype wire

// File: rtl/apb_slv_wait_ctr.sv
// ============================================================================
//  Module      : apb_slv_wait_ctr
//  Description : Wait-state counter: saturating load, decrement, zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slv_wait_ctr #(
    parameter int MAX_WAIT = 7,
    parameter int LOAD_W   = 3,
    parameter int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_dec,
    input  logic [LOAD_W-1:0] i_load_val,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            // Oversized requests clamp to the ceiling rather than wrapping.
            if (32'(i_load_val) > 32'(MAX_WAIT))
                r_cnt <= CNT_W'(MAX_WAIT);
            else
                r_cnt <= CNT_W'(i_load_val);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
//  Module      : apb_slave_mem
//  Description : APB3 completer fronting a register file, with programmable
//                wait states, out-of-range read errors and a sticky
//                protocol-violation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int VALID_ADDR = 31,
    parameter int MAX_WAIT   = 7
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [2:0]            wait_cfg,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  prot_err
);

    localparam int c_DEPTH = VALID_ADDR + 1;
    localparam int c_IDX_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_VALID_ADDR = ADDR_WIDTH'(VALID_ADDR);

    // Same layout as apb_req_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    apb_slv_state_t         r_state;
    req_t                   r_req;
    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic                   r_prot_err;

    logic [c_CNT_W-1:0]     w_cnt;
    logic                   w_cnt_zero;
    logic                   w_setup;
    logic                   w_same;
    logic                   w_access_ok;
    logic                   w_in_range;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_ready;
    logic [c_IDX_W-1:0]     w_idx;

    assign w_setup     = PSELx && !PENABLE;
    assign w_same      = (PADDR == r_req.addr) && (PWRITE == r_req.write) &&
                         (PWDATA == r_req.wdata);
    assign w_access_ok = PSELx && PENABLE && w_same;
    assign w_in_range  = (r_req.addr <= c_VALID_ADDR);
    assign w_idx       = r_req.addr[c_IDX_W-1:0];
    assign w_load      = (r_state == S_IDLE) && w_setup;
    assign w_dec       = (r_state == S_ACCESS) && w_access_ok && !w_cnt_zero;
    assign w_ready     = (r_state == S_ACCESS) && w_access_ok && w_cnt_zero;

    apb_slv_wait_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .LOAD_W   (3),
        .CNT_W    (c_CNT_W)
    ) u_wait_ctr (
        .clk        (PCLK),
        .rst        (PRESET),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (wait_cfg),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_prot_err <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_req   <= '{addr: PADDR, write: PWRITE, wdata: PWDATA};
                        r_state <= S_ACCESS;
                    end else if (PENABLE) begin
                        r_prot_err <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!w_access_ok) begin
                        r_prot_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (w_cnt_zero) begin
                        if (r_req.write && w_in_range)
                            r_mem[w_idx] <= r_req.wdata;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A transfer completing while reset is applied is aborted, so never report it.
    assign PREADY   = w_ready && !PRESET;
    assign PRDATA   = (PREADY && !r_req.write && w_in_range) ? r_mem[w_idx] : '0;
    assign PSLVERR  = PREADY && !r_req.write && !w_in_range;
    assign prot_err = r_prot_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
//  Module      : tb_apb_slave_mem
//  Description : Self-checking bench for apb_slave_mem against a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSELx = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [2:0]  wait_cfg = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        prot_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];

    apb_slave_mem dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .wait_cfg (wait_cfg),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .prot_err (prot_err)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
        return (addr <= 32'd31) ? model[addr[4:0]] : 32'd0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    // Drives one SETUP+ACCESS transfer; reports the ACCESS cycle on which
    // PREADY rose (0 = never) and how many waiting cycles showed nonzero outputs.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] wc, output logic [31:0] rd, output logic err,
                           output int lat, output int early_nz);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; wait_cfg = wc;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        wait_cfg = 3'($urandom);
        lat = 0; early_nz = 0; rd = '0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                lat = n; rd = PRDATA; err = PSLVERR;
                break;
            end
            if (PRDATA !== 32'd0 || PSLVERR !== 1'b0) early_nz++;
            @(posedge PCLK); #1;
        end
        if (wr && lat != 0 && addr <= 32'd31) model[addr[4:0]] = wd;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        total++;
        if ({PREADY, PSLVERR, prot_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got ready/err/prot=%b%b%b want 000", PREADY, PSLVERR, prot_err);
        end
        total++;
        if (PRDATA !== 32'd0) begin
            bad++;
            $display("FAIL reset_prdata: got %h want 0", PRDATA);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        clear_model();
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int lat, early;
        do_xfer(1'b1, 32'h5, 32'hDEADBEEF, 3'd0, rd, err, lat, early);
        total++;
        if (lat !== 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL wr_zero_wait: got lat=%0d err=%b want lat=1 err=0", lat, err);
        end
        do_xfer(1'b0, 32'h5, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat !== 1) begin
            bad++;
            $display("FAIL rd_after_wr: got %h err=%b lat=%0d want deadbeef err=0 lat=1", rd, err, lat);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int lat, early;
        do_xfer(1'b1, 32'h2, $urandom | 32'h1, 3'd0, rd, err, lat, early);
        do_xfer(1'b0, 32'h2, 32'h0, 3'd3, rd, err, lat, early);
        total++;
        if (lat !== 4 || early !== 0) begin
            bad++;
            $display("FAIL wait3_latency: got lat=%0d early_nz=%0d want lat=4 early_nz=0", lat, early);
        end
        total++;
        if (rd !== model[2]) begin
            bad++;
            $display("FAIL wait3_data: got %h want %h", rd, model[2]);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err; int lat, early;
        do_xfer(1'b1, 32'h0, $urandom | 32'h100, 3'd0, rd, err, lat, early);
        do_xfer(1'b0, 32'h20, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'd0) begin
            bad++;
            $display("FAIL oor_read: got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, err, rd);
        end
        do_xfer(1'b1, 32'h20, 32'h1, 3'd0, rd, err, lat, early);
        total++;
        if (lat !== 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL oor_write: got lat=%0d err=%b want lat=1 err=0", lat, err);
        end
        do_xfer(1'b0, 32'h0, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== model[0] || err !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_alias: got %h err=%b want %h err=0", rd, err, model[0]);
        end
        do_xfer(1'b1, 32'd31, 32'hA5A5_0031, 3'd1, rd, err, lat, early);
        do_xfer(1'b0, 32'd31, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'hA5A5_0031 || err !== 1'b0) begin
            bad++;
            $display("FAIL top_addr: got %h err=%b want a5a50031 err=0", rd, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat, early;
        for (int a = 1; a <= 3; a++) begin
            do_xfer(1'b1, 32'(a), $urandom, 3'd7, rd, err, lat, early);
            total++;
            if (lat !== 8 || err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_wr%0d: got lat=%0d err=%b want lat=8 err=0", a, lat, err);
            end
        end
        for (int a = 1; a <= 3; a++) begin
            do_xfer(1'b0, 32'(a), 32'h0, 3'd0, rd, err, lat, early);
            total++;
            if (rd !== model[a]) begin
                bad++;
                $display("FAIL b2b_rd%0d: got %h want %h", a, rd, model[a]);
            end
        end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, want_rd; logic err, wr, want_err; logic [2:0] wc; int lat, early;
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom);
            addr = $urandom_range(0, 40);
            wd   = $urandom;
            wc   = 3'($urandom_range(0, 7));
            want_rd  = exp_rdata(addr);
            want_err = !wr && (addr > 32'd31);
            do_xfer(wr, addr, wd, wc, rd, err, lat, early);
            total++;
            if ((!wr && rd !== want_rd) || err !== want_err || lat !== int'(wc) + 1 || early !== 0) begin
                bad++;
                $display("FAIL rand%0d: wr=%b addr=%0d got rd=%h err=%b lat=%0d early=%0d want rd=%h err=%b lat=%0d",
                         n, wr, addr, rd, err, lat, early, want_rd, want_err, int'(wc) + 1);
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
        @(negedge PCLK);
        total++;
        if (prot_err !== 1'b0) begin
            bad++;
            $display("FAIL rand_no_prot: got prot_err=%b want 0", prot_err);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic err; int lat, early; bit seen;
        seen = 1'b0;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hCAFE_0004; wait_cfg = 3'd3;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK); seen |= (PREADY === 1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(negedge PCLK); seen |= (PREADY === 1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
        clear_model();
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK); seen |= (PREADY === 1'b1);
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_ready: got PREADY asserted want never");
        end
        do_xfer(1'b0, 32'h4, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'd0 || lat !== 1) begin
            bad++;
            $display("FAIL abort_mem4: got %h lat=%0d want 0 lat=1", rd, lat);
        end
        do_xfer(1'b0, 32'h5, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("FAIL reset_clears_mem: got mem5=%h want 0", rd);
        end
        do_xfer(1'b1, 32'h4, 32'h1234_5678, 3'd2, rd, err, lat, early);
        do_xfer(1'b0, 32'h4, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'h1234_5678) begin
            bad++;
            $display("FAIL post_reset_xfer: got %h want 12345678", rd);
        end
        bus_idle();
    endtask

    task automatic test_protocol();
        logic [31:0] rd; logic err; int lat, early;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b1; PADDR = 32'h3; PWRITE = 1'b0;
        bus_idle();
        @(negedge PCLK);
        total++;
        if (prot_err !== 1'b1) begin
            bad++;
            $display("FAIL prot_no_setup: got %b want 1", prot_err);
        end
        do_xfer(1'b0, 32'h1, 32'h0, 3'd0, rd, err, lat, early);
        bus_idle();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        total++;
        if (prot_err !== 1'b1 || lat !== 1) begin
            bad++;
            $display("FAIL prot_sticky: got prot=%b lat=%0d want prot=1 lat=1", prot_err, lat);
        end
        @(posedge PCLK); #1; PRESET = 1'b1;
        @(posedge PCLK); #1; PRESET = 1'b0;
        clear_model();
        @(negedge PCLK);
        total++;
        if (prot_err !== 1'b0) begin
            bad++;
            $display("FAIL prot_reset: got %b want 0", prot_err);
        end
        do_xfer(1'b1, 32'h1, 32'h0000_00AA, 3'd0, rd, err, lat, early);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1; PWDATA = 32'h0000_00BB; wait_cfg = 3'd3;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1; PADDR = 32'h2;
        bus_idle();
        repeat (12) @(posedge PCLK);
        @(negedge PCLK);
        total++;
        if (prot_err !== 1'b1) begin
            bad++;
            $display("FAIL prot_addr_change: got %b want 1", prot_err);
        end
        do_xfer(1'b0, 32'h1, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'h0000_00AA) begin
            bad++;
            $display("FAIL prot_no_write1: got %h want 000000aa", rd);
        end
        do_xfer(1'b0, 32'h2, 32'h0, 3'd0, rd, err, lat, early);
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("FAIL prot_no_write2: got %h want 0", rd);
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
